rs_branch_sched: RTL
====================

RS_BRANCH_SCHED -- requirements
Module: rs_branch_sched

Interface
REQ-001 Parameters, one per line:
  - SIZE, 3, number of branch reservation-station entries.
  - SEL_W, 2, width of the entry select fields.
  - NONE, 2'b11, select code meaning "no entry".
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
  - clk  input  1  clock.
  - rst  input  1  asynchronous active-high reset.
  - rdy  input  1  global enable; no state changes while low.
  - clear  input  1  synchronous mispredict flush.
  - branch_enable  input  1  decoder requests allocation of one branch entry.
  - busy  input  SIZE  entry occupancy from the station.
  - ready_n  input  SIZE  per-entry readiness from the station, active-low: 0 means both operands are resolved.
  - alloc_addr  output  SEL_W  entry to allocate this cycle; NONE if there is no free entry.
  - issue_addr  output  SEL_W  entry to issue this cycle; NONE if there is no issuable entry.
  - stall  output  1  allocation request cannot be accepted.
  - stall_cycles  output  16  performance counter of stall cycles.

Function
REQ-004 Free entry selection: alloc_addr SHALL equal the lowest index i with busy[i]=0, or NONE if every entry is busy; this output is combinational.
REQ-005 Stall: stall SHALL equal branch_enable && (alloc_addr==NONE), combinationally.
REQ-006 Acceptance: an allocation SHALL be accepted only when rdy && branch_enable && !stall && !clear.
REQ-007 Issue candidates: entry i SHALL be a candidate iff busy[i]=1 and ready_n[i]=0.
REQ-008 Issue gating: issue_addr SHALL be NONE when rdy=0, when clear=1, or when there are no candidates.
REQ-009 Same-cycle issue: an entry issued in cycle N SHALL NOT be reused for allocation in cycle N, because alloc_addr uses busy as sampled in that cycle.
REQ-010 Age matrix: the block SHALL hold an age matrix older[i][j] (i != j), meaning entry i was allocated before entry j.
REQ-011 On an accepted allocation to entry k, at the next edge:
  - older[j][k] SHALL be set to busy[j] for every j != k.
  - older[k][j] SHALL be set to 0 for every j.
REQ-012 Age bits of an entry issued this cycle need not be cleared; they SHALL be ignored because busy gates candidacy.
REQ-013 Simultaneous allocate and issue in the same cycle SHALL both take effect: the issued entry is treated as still busy when computing the new entry's age bits.
REQ-014 stall_cycles SHALL increment by 1 on each rdy cycle with stall=1 and wrap from 16'hFFFF to 0; clear SHALL NOT reset it.
REQ-015 clear SHALL zero the age matrix at the next edge.
REQ-016 While rdy=0, all registers SHALL hold their values.

Reset
REQ-017 While rst=1, asynchronously: the age matrix SHALL be 0 and stall_cycles SHALL be 0.
REQ-018 During reset, the combinational outputs follow REQ-004, REQ-005 and REQ-008 from the current inputs.
REQ-019 Reset asserted mid-operation SHALL discard all age state within the same cycle, without waiting for a clock edge.

Configuration
REQ-020 Macro RS_BRANCH_SCHED_OLDEST_EN defined: issue_addr SHALL select the candidate i for which no other candidate j has older[j][i]=1 (oldest first).
REQ-021 Macro RS_BRANCH_SCHED_OLDEST_EN undefined:
  - issue_addr SHALL select the lowest-index candidate.
  - The age matrix SHALL NOT be instantiated.
  - All other behaviour SHALL be identical.

Verification
REQ-022 Reset then idle: rst=1 -> stall_cycles=0; with busy=000, alloc_addr=0 and issue_addr=NONE.
REQ-023 Fill: busy=011, branch_enable=1 -> alloc_addr=2, stall=0; then busy=111 -> alloc_addr=NONE, stall=1, and stall_cycles increments each rdy cycle.
REQ-024 Age order (macro defined): allocate entry 2, then 0, then 1, with ready_n=000 and busy=111 -> issue_addr=2; with busy=011 -> issue_addr=0. Macro undefined, same sequence -> issue_addr=0 first.
REQ-025 Simultaneous events: busy=111, ready_n=011, branch_enable=1 -> issue_addr=2 and stall=1; next cycle with busy=011 -> alloc_addr=2 accepted, and entry 2 is younger than entries 0 and 1.
REQ-026 Flush and gating: clear=1 with candidates present -> issue_addr=NONE and the age matrix is zero next cycle; rdy=0 -> issue_addr=NONE and stall_cycles unchanged.
REQ-027 Counter wrap: preload or run stall_cycles to 16'hFFFF, then one further stall cycle -> 0.

Source files
------------

// File: rtl/rs_branch_sched.sv
// rs_branch_sched -- select logic for a small branch reservation station.
//
// Picks the lowest free entry for allocation, picks one issuable entry
// (busy and both operands resolved) for issue, raises stall when an
// allocation request finds no free entry, and counts stall cycles.
//
// Configuration macro: RS_BRANCH_SCHED_OLDEST_EN
//   defined   : an age matrix tracks allocation order and issue picks the
//               oldest issuable entry.
//   undefined : no age matrix; issue picks the lowest-index issuable entry.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   rdy           global enable; registers hold while low
//   clear         synchronous mispredict flush (wipes age state)
//   branch_enable decoder wants one branch entry this cycle
//   busy          entry occupancy from the station
//   ready_n       per-entry readiness, active-low (0 = operands resolved)
//   alloc_addr    lowest free entry, NONE when full (combinational)
//   issue_addr    entry to issue, NONE when nothing issuable/gated
//   stall         allocation request cannot be accepted
//   stall_cycles  wrapping count of enabled cycles spent stalled
module rs_branch_sched #(
  parameter int               SIZE  = 3,
  parameter int               SEL_W = 2,
  parameter logic [SEL_W-1:0] NONE  = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             branch_enable,
  input  logic [SIZE-1:0]  busy,
  input  logic [SIZE-1:0]  ready_n,
  output logic [SEL_W-1:0] alloc_addr,
  output logic [SEL_W-1:0] issue_addr,
  output logic             stall,
  output logic [15:0]      stall_cycles
);

  logic [SIZE-1:0] cand_s;
  logic [SIZE-1:0] pick_s;
  logic [15:0]     stall_cnt_q;
  logic [15:0]     stall_cnt_d;

  // Issue candidates: occupied entries whose operands are resolved.
  assign cand_s = busy & ~ready_n;

  // Lowest free entry; scanning downward lets the lowest index win.
  always_comb begin
    alloc_addr = NONE;
    for (int i = SIZE - 1; i >= 0; i--) begin
      alloc_addr = busy[i] ? alloc_addr : SEL_W'(i);
    end
  end

  assign stall = branch_enable && (alloc_addr == NONE);

`ifdef RS_BRANCH_SCHED_OLDEST_EN
  // older_q[i][j] = 1 means entry i was allocated before entry j.
  // The diagonal is never set.
  logic [SIZE-1:0][SIZE-1:0] older_q;
  logic [SIZE-1:0][SIZE-1:0] older_d;
  logic                      accept_s;

  assign accept_s = rdy && branch_enable && !stall && !clear;

  // Oldest candidates: no other candidate is older than them. Stale age
  // bits of freed entries are harmless because only candidates vote.
  always_comb begin
    pick_s = '0;
    for (int i = 0; i < SIZE; i++) begin
      pick_s[i] = cand_s[i];
      for (int j = 0; j < SIZE; j++) begin
        if ((j != i) && cand_s[j] && older_q[j][i]) begin
          pick_s[i] = 1'b0;
        end else begin
          pick_s[i] = pick_s[i];
        end
      end
    end
  end

  // Age matrix next state. The new entry is younger than everything busy
  // right now, including an entry issuing this same cycle.
  always_comb begin
    older_d = older_q;
    if (clear) begin
      older_d = '0;
    end else if (accept_s) begin
      for (int k = 0; k < SIZE; k++) begin
        if (SEL_W'(k) == alloc_addr) begin
          for (int j = 0; j < SIZE; j++) begin
            older_d[k][j] = 1'b0;
            older_d[j][k] = (j != k) ? busy[j] : 1'b0;
          end
        end else begin
          older_d[k] = older_d[k];
        end
      end
    end else begin
      older_d = older_q;
    end
  end

  // Age matrix register; reset wipes age state without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else if (rdy) begin
      older_q <= older_d;
    end else begin
      older_q <= older_q;
    end
  end
`else
  // Without age tracking every candidate is eligible; lowest index wins.
  always_comb begin
    pick_s = cand_s;
  end
`endif

  // Issue select: lowest eligible index, forced to NONE when disabled or flushing.
  always_comb begin
    issue_addr = NONE;
    for (int i = SIZE - 1; i >= 0; i--) begin
      issue_addr = pick_s[i] ? SEL_W'(i) : issue_addr;
    end
    if (!rdy || clear) begin
      issue_addr = NONE;
    end else begin
      issue_addr = issue_addr;
    end
  end

  // Stall counter next state; wraps naturally and ignores clear.
  always_comb begin
    if (rdy && stall) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
